// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with optional return-address stack
// The return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        call,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic        ret,
   output logic [31:0] pc,
   output logic [31:0] pcplus1,
   output logic        ras_empty,
   output logic        ras_full,
   output logic        ras_overflow
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] branch_pc, jump_pc, ret_pc;

   assign pc        = pc_q;
   assign pcplus1   = pc_q + 32'd1;
   assign branch_pc = pcplus1 + branch_offset;
   assign jump_pc   = {pcplus1[31:26], jump_target};

`ifdef PC_SEQ_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [PW-1:0] TOP_IDX  = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

   logic [31:0]   ras_mem [RAS_DEPTH];
   logic [PW-1:0] tos_q, tos_d, tos_inc, tos_dec;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          push, pop;

   // tos_q points at the newest entry; the slot after it holds the oldest when full
   assign tos_inc = (tos_q == TOP_IDX) ? '0 : tos_q + PW'(1);
   assign tos_dec = (tos_q == '0) ? TOP_IDX : tos_q - PW'(1);

   assign ras_empty    = (cnt_q == '0);
   assign ras_full     = (cnt_q == FULL_CNT);
   assign ras_overflow = ovf_q;

   assign pop    = !stall && ret && !ras_empty;
   assign push   = !stall && call && !ret && !jr;
   assign ret_pc = ras_empty ? jr_addr : ras_mem[tos_q];

   always_comb begin
      tos_d = tos_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (pop) begin
         tos_d = tos_dec;
         cnt_d = cnt_q - CW'(1);
      end else if (push) begin
         tos_d = tos_inc;
         if (ras_full) ovf_d = 1'b1;
         else          cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tos_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         tos_q <= tos_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) ras_mem[tos_inc] <= pcplus1;
   end
`else
   assign ras_empty    = 1'b1;
   assign ras_full     = 1'b0;
   assign ras_overflow = 1'b0;
   assign ret_pc       = jr_addr;
`endif

   always_comb begin
      pc_d = pc_q;
      if (!stall) begin
         if (ret)                 pc_d = ret_pc;
         else if (jr)             pc_d = jr_addr;
         else if (jump || call)   pc_d = jump_pc;
         else if (branch_taken)   pc_d = branch_pc;
         else                     pc_d = pcplus1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branch_taken, jump, call, jr, ret;
   logic [31:0] branch_offset, jr_addr;
   logic [25:0] jump_target;
   logic [31:0] pc, pcplus1;
   logic        ras_empty, ras_full, ras_overflow;

   logic [31:0] exp_q[$];
   logic [31:0] ras_model[$];
   int checks = 0;
   int errors = 0;

   pc_sequencer #(.RESET_PC(32'h0000_0100), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .call(call),
      .jr(jr), .jr_addr(jr_addr), .ret(ret),
      .pc(pc), .pcplus1(pcplus1), .ras_empty(ras_empty),
      .ras_full(ras_full), .ras_overflow(ras_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      stall = 0; branch_taken = 0; jump = 0; call = 0; jr = 0; ret = 0;
      branch_offset = '0; jr_addr = '0; jump_target = '0;
   endtask

   // expected next pc is queued when the inputs are applied, compared after the edge
   task automatic step(input string tag, input logic [31:0] exp);
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      chk(tag, pc, exp_q.pop_front());
   endtask

   task automatic goto_pc(input logic [31:0] a);
      idle();
      jr = 1; jr_addr = a;
      step("jr_setup", a);
      idle();
   endtask

   initial begin
      logic [31:0] p;
      logic [25:0] t;
      idle();
      reset = 1;
      #1;
      chk("reset_pc", pc, 32'h100);
      chk("reset_empty", {31'd0, ras_empty}, 32'd1);
      chk("reset_full", {31'd0, ras_full}, 32'd0);
      chk("reset_ovf", {31'd0, ras_overflow}, 32'd0);
      @(posedge clk); #1;
      reset = 0;
      chk("pc0", pc, 32'h100);
      step("pc1", 32'h101);
      step("pc2", 32'h102);
      step("pc3", 32'h103);
      chk("pcplus1", pcplus1, 32'h104);

      goto_pc(32'h40);
      branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
      step("branch_neg", 32'h3F);
      goto_pc(32'h0400_0010);
      jump = 1; jump_target = 26'h3;
      step("jump", 32'h0400_0003);

      goto_pc(32'hFFFF_FFFF);
      chk("pcplus1_wrap", pcplus1, 32'h0);
      step("pc_wrap", 32'h0);

`ifdef PC_SEQ_RAS_EN
      goto_pc(32'h10);
      call = 1; jump_target = 26'h80;
      step("call", 32'h80);
      idle();
      chk("call_nonempty", {31'd0, ras_empty}, 32'd0);
      for (int i = 1; i <= 5; i++) step("run_to_85", 32'h80 + i);
      ret = 1;
      step("ret", 32'h11);
      idle();
      chk("ret_empty", {31'd0, ras_empty}, 32'd1);

      goto_pc(32'h1000);
      p = 32'h1000;
      for (int i = 0; i < 5; i++) begin
         t = 26'h2000 + 26'(i * 32'h100);
         call = 1; jump_target = t;
         ras_model.push_back(p + 1);
         if (ras_model.size() > 4) void'(ras_model.pop_front());
         p = {p[31:26] + ((p + 1) >> 26) - p[31:26], t};
         step("call_n", p);
         if (i == 3) begin
            chk("full4", {31'd0, ras_full}, 32'd1);
            chk("no_ovf4", {31'd0, ras_overflow}, 32'd0);
         end
      end
      idle();
      chk("full5", {31'd0, ras_full}, 32'd1);
      chk("ovf5", {31'd0, ras_overflow}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         ret = 1; jr_addr = 32'h777;
         step("ret_n", ras_model.pop_back());
      end
      chk("empty_after4", {31'd0, ras_empty}, 32'd1);
      step("ret_empty_jr", 32'h777);
      idle();
      chk("ovf_sticky", {31'd0, ras_overflow}, 32'd1);

      goto_pc(32'h500);
      call = 1; jump_target = 26'h600;
      step("callA", 32'h600);
      jump_target = 26'h700;
      step("callB", 32'h700);
      stall = 1; call = 1; ret = 1; jump_target = 26'h900;
      for (int i = 0; i < 3; i++) step("stall_hold", 32'h700);
      chk("stall_nonempty", {31'd0, ras_empty}, 32'd0);
      stall = 0;
      step("callret_pop", 32'h601);
      idle();
      ret = 1;
      step("pop_second", 32'h501);
      idle();
      chk("callret_empty", {31'd0, ras_empty}, 32'd1);
`else
      goto_pc(32'h10);
      call = 1; jump_target = 26'h80;
      step("call_as_jump", 32'h80);
      idle();
      chk("noras_empty", {31'd0, ras_empty}, 32'd1);
      ret = 1; jr_addr = 32'h345;
      step("ret_as_jr", 32'h345);
      idle();
      chk("noras_full", {31'd0, ras_full}, 32'd0);
      chk("noras_ovf", {31'd0, ras_overflow}, 32'd0);
      stall = 1; ret = 1; jr_addr = 32'h999;
      step("stall_hold", 32'h345);
      idle();
`endif

      goto_pc(32'h2000);
      call = 1; jump_target = 26'h3000;
      reset = 1;
      #1;
      chk("midreset_pc", pc, 32'h100);
      chk("midreset_empty", {31'd0, ras_empty}, 32'd1);
      @(posedge clk); #1;
      reset = 0;
      idle();
      step("after_reset", 32'h101);
      chk("after_reset_empty", {31'd0, ras_empty}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the word address loaded into pc on reset.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, the number of return-address stack entries (legal range 2..16).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port stall  input  1  hold pc and stack contents this cycle.
REQ-006 The block SHALL have port branch_taken  input  1  take the branch target.
REQ-007 The block SHALL have port branch_offset  input  32  sign-extended word offset.
REQ-008 The block SHALL have port jump  input  1  take the jump target.
REQ-009 The block SHALL have port jump_target  input  26  instruction target field.
REQ-010 The block SHALL have port call  input  1  jump and push pcplus1 onto the return-address stack.
REQ-011 The block SHALL have port jr  input  1  jump to jr_addr.
REQ-012 The block SHALL have port jr_addr  input  32  register-sourced target.
REQ-013 The block SHALL have port ret  input  1  pop the stack and go to the popped address.
REQ-014 The block SHALL have port pc  output  32  registered current word address.
REQ-015 The block SHALL have port pcplus1  output  32  pc+1, combinational.
REQ-016 The block SHALL have port ras_empty  output  1  stack holds no entries.
REQ-017 The block SHALL have port ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-018 The block SHALL have port ras_overflow  output  1  sticky flag: an entry was lost.

Function
REQ-019 The block SHALL compute pcplus1 = pc + 1 modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-020 The block SHALL compute the branch target as pcplus1 + branch_offset modulo 2^32.
REQ-021 The block SHALL compute the jump target as {pcplus1[31:26], jump_target}.
REQ-022 The block SHALL select the next pc with fixed priority: stall (hold), then ret, then jr, then jump or call, then branch_taken, then pcplus1.
REQ-023 On call without stall, the block SHALL take the jump target and push pcplus1 onto the stack in the same edge; pc updates with 1-cycle latency.
REQ-024 On ret with a non-empty stack, the block SHALL take the top entry as next pc and pop it.
REQ-025 On ret with an empty stack, the block SHALL use jr_addr as next pc, and the stack SHALL be unchanged.
REQ-026 On a push to a full stack, the block SHALL overwrite the oldest entry (circular), leave depth at RAS_DEPTH, and set ras_overflow.
REQ-027 When call and ret are asserted together, ret SHALL win: pop only, no push.
REQ-028 With stall high, pc, the stack pointer, the depth count and the stack contents SHALL all hold, whatever the other inputs are.
REQ-029 Once set, ras_overflow SHALL stay set until reset.

Reset
REQ-030 Asserting reset SHALL immediately set pc=RESET_PC, depth=0, ras_empty=1, ras_full=0 and ras_overflow=0; stack contents are don't-care.
REQ-031 Reset asserted mid-operation SHALL discard any pending push or pop; the first update after deassertion SHALL follow REQ-022.

Configuration
REQ-032 With macro PC_SEQ_RAS_EN defined, the block SHALL implement the return-address stack as specified above.
REQ-033 Without PC_SEQ_RAS_EN, the block SHALL contain no stack storage. call SHALL behave as jump, ret SHALL behave as jr, and the outputs SHALL be tied ras_empty=1, ras_full=0, ras_overflow=0.

Verification
REQ-034 The bench SHALL check: reset with RESET_PC=0x100, then 3 free-running cycles -> pc reads 0x100, 0x101, 0x102, 0x103.
REQ-035 The bench SHALL check: pc=0x40, branch_taken, branch_offset=-2 -> next pc=0x3F; jump with pc=0x0400_0010, jump_target=0x3 -> next pc=0x0400_0003.
REQ-036 The bench SHALL check: call at pc=0x10 with target 0x80, then ret at 0x85 -> pc 0x80, then 0x11, with ras_empty=1 afterwards.
REQ-037 The bench SHALL check: 5 calls with RAS_DEPTH=4 -> ras_full=1 and ras_overflow=1; 4 rets return the last 4 pushed addresses; a 5th ret goes to jr_addr.
REQ-038 The bench SHALL check: stall held 3 cycles while ret and call are asserted -> pc and depth unchanged; call+ret together unstalled -> pop only.
REQ-039 The bench SHALL check: pc=0xFFFF_FFFF free-running -> next pc=0; with PC_SEQ_RAS_EN undefined, ret -> next pc=jr_addr.
